s3g_port_mux: RTL and testbench

S3G_PORT_MUX -- requirements
Module: s3g_port_mux

---
 rtl/s3g_mux_pkg.sv | 19 +
 rtl/s3g_port_fifo.sv | 45 ++++
 rtl/s3g_port_mux.sv | 199 +++++++++++++++++++
 tb/tb_s3g_port_mux.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_mux_pkg.sv
// Shared definitions for the multi-port UART mux: RX lock states, TX target modes
// and a width helper used for port-index and counter sizing.
package s3g_mux_pkg;

  typedef enum logic {
    RX_UNLOCKED = 1'b0,
    RX_LOCKED   = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_REPLY     = 1'b0,
    TX_BROADCAST = 1'b1
  } tx_mode_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s3g_port_fifo.sv
// Per-port RX byte FIFO. A push into a full FIFO and a pop from an empty one
// are ignored; full/empty reflect the state before the current edge.
module s3g_port_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rd_data   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/s3g_port_mux.sv
// Merges N UART RX streams into one packet stream under a per-packet lock, and
// fans TX bytes out to either all ports or the most recent RX owner.
module s3g_port_mux
  import s3g_mux_pkg::*;
#(
  parameter  int unsigned N_PORTS      = 2,
  parameter  int unsigned FIFO_DEPTH   = 4,
  parameter  int unsigned LOCK_TIMEOUT = 50000,
  localparam int unsigned PW           = clog2_min1(N_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*N_PORTS-1:0] port_rx_data,
  input  logic [N_PORTS-1:0]   port_rx_done,
  output logic [7:0]           rx_data,
  output logic                 rx_done,
  output logic [PW-1:0]        rx_port,
  input  logic                 packet_end,
  input  logic [7:0]           tx_data,
  input  logic                 tx_wr,
  input  logic                 tx_broadcast,
  output logic [7:0]           port_tx_data,
  output logic [N_PORTS-1:0]   port_tx_wr,
  input  logic [N_PORTS-1:0]   port_tx_done,
  output logic                 tx_done,
  output logic                 tx_busy,
  output logic                 locked,
  output logic [PW-1:0]        lock_port,
  output logic [N_PORTS-1:0]   overflow,
  input  logic                 clear_overflow
);

  localparam int unsigned IW = clog2_min1(LOCK_TIMEOUT + 1);

  logic [N_PORTS-1:0] w_full;
  logic [N_PORTS-1:0] w_empty;
  logic [N_PORTS-1:0] w_pop;
  logic [7:0]         w_fifo_dout [N_PORTS];

  rx_state_e          r_state;
  rx_state_e          w_state_nxt;
  logic [PW-1:0]      r_lock_port;
  logic [PW-1:0]      w_lock_port_nxt;
  logic [PW-1:0]      w_pop_port;
  logic               w_pop_any;
  logic [IW-1:0]      r_idle;
  logic [IW-1:0]      w_idle_nxt;
  logic               w_idle_timeout;
  logic [PW-1:0]      w_rr_idx;
  logic [PW-1:0]      w_rr_sel;
  logic               w_rr_found;

  logic [7:0]         r_rx_data;
  logic               r_rx_done;
  logic [PW-1:0]      r_rx_port;
  logic [N_PORTS-1:0] r_overflow;

  tx_mode_e           w_tx_mode;
  logic [N_PORTS-1:0] w_tx_target;
  logic [N_PORTS-1:0] w_pend_left;
  logic [N_PORTS-1:0] r_tx_pend;
  logic [N_PORTS-1:0] r_port_tx_wr;
  logic [7:0]         r_port_tx_data;
  logic               r_tx_busy;
  logic               r_tx_done;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
    s3g_port_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (port_rx_done[g]),
      .pop     (w_pop[g]),
      .wr_data (port_rx_data[8*g +: 8]),
      .rd_data (w_fifo_dout[g]),
      .full    (w_full[g]),
      .empty   (w_empty[g])
    );
  end

  // Round-robin search begins one past the previous owner.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = '0;
    w_rr_idx   = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      w_rr_idx = PW'((32'(r_lock_port) + 32'd1 + k) % N_PORTS);
      if (!w_rr_found && !w_empty[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = w_rr_idx;
      end
    end
  end

  assign w_idle_timeout = (32'(r_idle) + 32'd1) >= LOCK_TIMEOUT;

  always_comb begin
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    w_pop_port      = r_lock_port;
    w_pop_any       = 1'b0;
    w_idle_nxt      = r_idle;
    w_pop           = '0;
    case (r_state)
      RX_UNLOCKED: begin
        if (w_rr_found) begin
          w_state_nxt     = RX_LOCKED;
          w_lock_port_nxt = w_rr_sel;
          w_pop_port      = w_rr_sel;
          w_pop_any       = 1'b1;
          w_idle_nxt      = '0;
        end
      end
      RX_LOCKED: begin
        if (!w_empty[r_lock_port]) begin
          w_pop_any  = 1'b1;
          w_idle_nxt = '0;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
        if (packet_end || (!w_pop_any && w_idle_timeout)) begin
          w_state_nxt = RX_UNLOCKED;
          w_idle_nxt  = '0;
        end
      end
      default: w_state_nxt = RX_UNLOCKED;
    endcase
    if (w_pop_any) w_pop[w_pop_port] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RX_UNLOCKED;
      r_lock_port <= '0;
      r_idle      <= '0;
      r_rx_data   <= '0;
      r_rx_done   <= 1'b0;
      r_rx_port   <= '0;
      r_overflow  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_port_nxt;
      r_idle      <= w_idle_nxt;
      r_rx_done   <= w_pop_any;
      if (w_pop_any) begin
        r_rx_data <= w_fifo_dout[w_pop_port];
        r_rx_port <= w_pop_port;
      end
      r_overflow <= (clear_overflow ? '0 : r_overflow) | (port_rx_done & w_full);
    end
  end

  assign w_tx_mode   = tx_mode_e'(tx_broadcast);
  assign w_pend_left = r_tx_pend & ~port_tx_done;

  always_comb begin
    w_tx_target = '0;
    if (w_tx_mode == TX_BROADCAST) w_tx_target = '1;
    else                           w_tx_target[r_lock_port] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_tx_pend      <= '0;
      r_port_tx_wr   <= '0;
      r_port_tx_data <= '0;
    end else begin
      r_port_tx_wr <= '0;
      r_tx_done    <= 1'b0;
      if (r_tx_busy) begin
        r_tx_pend <= w_pend_left;
        if (w_pend_left == '0) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end
      end else if (tx_wr) begin
        r_tx_busy      <= 1'b1;
        r_tx_pend      <= w_tx_target;
        r_port_tx_wr   <= w_tx_target;
        r_port_tx_data <= tx_data;
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_done      = r_rx_done;
  assign rx_port      = r_rx_port;
  assign locked       = (r_state == RX_LOCKED);
  assign lock_port    = r_lock_port;
  assign overflow     = r_overflow;
  assign port_tx_data = r_port_tx_data;
  assign port_tx_wr   = r_port_tx_wr;
  assign tx_done      = r_tx_done;
  assign tx_busy      = r_tx_busy;

endmodule

// File: tb/tb_s3g_port_mux.sv
// Self-checking bench for s3g_port_mux: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_s3g_port_mux;

  localparam int unsigned NP = 2;
  localparam int unsigned FD = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned PW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*NP-1:0] port_rx_data;
  logic [NP-1:0]   port_rx_done;
  logic [7:0]      rx_data;
  logic            rx_done;
  logic [PW-1:0]   rx_port;
  logic            packet_end;
  logic [7:0]      tx_data;
  logic            tx_wr;
  logic            tx_broadcast;
  logic [7:0]      port_tx_data;
  logic [NP-1:0]   port_tx_wr;
  logic [NP-1:0]   port_tx_done;
  logic            tx_done;
  logic            tx_busy;
  logic            locked;
  logic [PW-1:0]   lock_port;
  logic [NP-1:0]   overflow;
  logic            clear_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  s3g_port_mux #(
    .N_PORTS      (NP),
    .FIFO_DEPTH   (FD),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_rx_data   (port_rx_data),
    .port_rx_done   (port_rx_done),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .rx_port        (rx_port),
    .packet_end     (packet_end),
    .tx_data        (tx_data),
    .tx_wr          (tx_wr),
    .tx_broadcast   (tx_broadcast),
    .port_tx_data   (port_tx_data),
    .port_tx_wr     (port_tx_wr),
    .port_tx_done   (port_tx_done),
    .tx_done        (tx_done),
    .tx_busy        (tx_busy),
    .locked         (locked),
    .lock_port      (lock_port),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Reference model: byte queues per port, lock owner, idle count, pending TX set.
  logic [7:0]  m_q [NP][$];
  logic        m_locked = 1'b0;
  int unsigned m_owner = 0;
  int unsigned m_idle = 0;
  logic        m_rx_done = 1'b0;
  logic [7:0]  m_rx_data = '0;
  int unsigned m_rx_port = 0;
  logic [NP-1:0] m_ovf = '0;
  logic        m_busy = 1'b0;
  logic        m_tx_done = 1'b0;
  logic [NP-1:0] m_pend = '0;
  logic [NP-1:0] m_ptx_wr = '0;
  logic [7:0]  m_ptx_data = '0;
  logic [NP-1:0] mv_full;
  bit          mv_found;
  int unsigned mv_start;
  int unsigned mv_pick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) m_q[i].delete();
      m_locked = 1'b0; m_owner = 0; m_idle = 0;
      m_rx_done = 1'b0; m_rx_data = '0; m_rx_port = 0; m_ovf = '0;
      m_busy = 1'b0; m_tx_done = 1'b0; m_pend = '0; m_ptx_wr = '0; m_ptx_data = '0;
    end else begin
      m_ptx_wr = '0;
      m_tx_done = 1'b0;
      if (m_busy) begin
        m_pend = m_pend & ~port_tx_done;
        if (m_pend == '0) begin
          m_busy = 1'b0;
          m_tx_done = 1'b1;
        end
      end else if (tx_wr) begin
        m_busy = 1'b1;
        m_pend = tx_broadcast ? '1 : (NP'(1) << m_owner);
        m_ptx_wr = m_pend;
        m_ptx_data = tx_data;
      end
      for (int i = 0; i < NP; i++) mv_full[i] = (m_q[i].size() == FD);
      m_rx_done = 1'b0;
      if (!m_locked) begin
        mv_found = 1'b0;
        mv_start = m_owner + 1;
        for (int k = 0; k < NP; k++) begin
          mv_pick = (mv_start + k) % NP;
          if (!mv_found && m_q[mv_pick].size() != 0) begin
            mv_found = 1'b1;
            m_owner = mv_pick;
          end
        end
        if (mv_found) begin
          m_locked = 1'b1;
          m_idle = 0;
          m_rx_done = 1'b1;
          m_rx_port = m_owner;
          m_rx_data = m_q[m_owner].pop_front();
        end
      end else begin
        if (m_q[m_owner].size() != 0) begin
          m_rx_done = 1'b1;
          m_rx_port = m_owner;
          m_rx_data = m_q[m_owner].pop_front();
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if (packet_end || m_idle == LT) begin
          m_locked = 1'b0;
          m_idle = 0;
        end
      end
      if (clear_overflow) m_ovf = '0;
      for (int i = 0; i < NP; i++) begin
        if (port_rx_done[i]) begin
          if (mv_full[i]) m_ovf[i] = 1'b1;
          else            m_q[i].push_back(port_rx_data[8*i +: 8]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    port_rx_data = '0; port_rx_done = '0; packet_end = 1'b0;
    tx_data = '0; tx_wr = 1'b0; tx_broadcast = 1'b0;
    port_tx_done = '0; clear_overflow = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    tests++;
    if (rx_done !== 1'b0 || rx_data !== 8'h00 || rx_port !== '0) begin
      fails++;
      $display("FAIL reset_rx: rx_done=%b rx_data=%h rx_port=%0d, required 0/00/0", rx_done, rx_data, rx_port);
    end
    tests++;
    if (locked !== 1'b0 || lock_port !== '0 || overflow !== '0) begin
      fails++;
      $display("FAIL reset_lock: locked=%b lock_port=%0d overflow=%b, required 0/0/00", locked, lock_port, overflow);
    end
    tests++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0 || port_tx_wr !== '0 || port_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx: busy=%b done=%b wr=%b data=%h, required 0/0/00/00", tx_busy, tx_done, port_tx_wr, port_tx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_byte;
    int unsigned lat;
    bit seen;
    port_rx_data = {8'h55, 8'h00};
    port_rx_done = 2'b10;
    tick();
    idle_inputs();
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (rx_done === 1'b1) seen = 1'b1;
      else begin tick(); lat++; end
    end
    tests++;
    if (!seen || lat != 2) begin
      fails++;
      $display("FAIL single_latency: seen=%0b cycles=%0d, required 1/2", seen, lat);
    end
    tests++;
    if (rx_data !== 8'h55 || rx_port !== 1'b1 || locked !== 1'b1 || lock_port !== 1'b1) begin
      fails++;
      $display("FAIL single_data: rx_data=%h rx_port=%0d locked=%b lock_port=%0d, required 55/1/1/1",
               rx_data, rx_port, locked, lock_port);
    end
    packet_end = 1'b1;
    tick();
    packet_end = 1'b0;
    tests++;
    if (locked !== 1'b0 || rx_done !== 1'b0) begin
      fails++;
      $display("FAIL single_release: locked=%b rx_done=%b, required 0/0", locked, rx_done);
    end
  endtask

  task automatic test_lock_hold;
    logic [7:0] got_d [$];
    logic [PW-1:0] got_p [$];
    port_rx_data = {8'h00, 8'h11};
    port_rx_done = 2'b01;
    tick();
    idle_inputs();
    tick();
    tests++;
    if (rx_done !== 1'b1 || rx_data !== 8'h11 || rx_port !== 1'b0 || locked !== 1'b1 || lock_port !== 1'b0) begin
      fails++;
      $display("FAIL hold_lock0: rx_done=%b data=%h port=%0d locked=%b lock_port=%0d, required 1/11/0/1/0",
               rx_done, rx_data, rx_port, locked, lock_port);
    end
    port_rx_data = {8'hAA, 8'h00}; port_rx_done = 2'b10;
    tick();
    port_rx_data = {8'hBB, 8'h00}; port_rx_done = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rx_done !== 1'b0) begin
        fails++;
        $display("FAIL hold_blocked: rx_done=%b while locked on port 0, required 0", rx_done);
      end
      tick();
      idle_inputs();
    end
    packet_end = 1'b1;
    tick();
    packet_end = 1'b0;
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: locked=%b, required 0", locked);
    end
    for (int i = 0; i < 8; i++) begin
      if (rx_done === 1'b1) begin
        got_d.push_back(rx_data);
        got_p.push_back(rx_port);
      end
      tick();
    end
    tests++;
    if (got_d.size() != 2 || got_d[0] !== 8'hAA || got_d[1] !== 8'hBB || got_p[0] !== 1'b1 || got_p[1] !== 1'b1) begin
      fails++;
      $display("FAIL hold_bytes: count=%0d, required 2 bytes AA,BB from port 1", got_d.size());
    end
  endtask

  task automatic test_timeout;
    int unsigned n;
    for (int i = 0; i < 40 && locked === 1'b1; i++) tick();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL timeout_wait: locked=%b after 40 cycles, required 0", locked);
    end
    port_rx_data = {8'h77, 8'h00}; port_rx_done = 2'b10;
    tick();
    idle_inputs();
    for (int i = 0; i < 8 && rx_done !== 1'b1; i++) tick();
    tests++;
    if (rx_done !== 1'b1 || rx_data !== 8'h77 || lock_port !== 1'b1) begin
      fails++;
      $display("FAIL timeout_pop: rx_done=%b data=%h lock_port=%0d, required 1/77/1", rx_done, rx_data, lock_port);
    end
    n = 0;
    while (locked === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests++;
    if (locked !== 1'b0 || n != LT) begin
      fails++;
      $display("FAIL timeout_len: locked=%b released after %0d cycles, required 0 after %0d", locked, n, LT);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] got_d [$];
    bit port_ok;
    port_rx_data = {8'h00, 8'h01}; port_rx_done = 2'b01;
    tick();
    idle_inputs();
    tick();
    tests++;
    if (rx_done !== 1'b1 || lock_port !== 1'b0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL ovf_lock0: rx_done=%b lock_port=%0d locked=%b, required 1/0/1", rx_done, lock_port, locked);
    end
    for (int k = 0; k < 5; k++) begin
      port_rx_data = {8'hA0 + 8'(k), 8'h00};
      port_rx_done = 2'b10;
      tick();
      if (k == 3) begin
        tests++;
        if (overflow !== 2'b00) begin
          fails++;
          $display("FAIL ovf_early: overflow=%b after 4 bytes, required 00", overflow);
        end
      end
    end
    idle_inputs();
    tests++;
    if (overflow !== 2'b10) begin
      fails++;
      $display("FAIL ovf_set: overflow=%b after 5 bytes, required 10", overflow);
    end
    packet_end = 1'b1;
    tick();
    packet_end = 1'b0;
    port_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rx_done === 1'b1) begin
        got_d.push_back(rx_data);
        if (rx_port !== 1'b1) port_ok = 1'b0;
      end
      tick();
    end
    tests++;
    if (got_d.size() != 4 || !port_ok || got_d[0] !== 8'hA0 || got_d[1] !== 8'hA1 ||
        got_d[2] !== 8'hA2 || got_d[3] !== 8'hA3) begin
      fails++;
      $display("FAIL ovf_bytes: count=%0d port_ok=%0b, required 4 bytes A0..A3 from port 1", got_d.size(), port_ok);
    end
    tests++;
    if (overflow !== 2'b10) begin
      fails++;
      $display("FAIL ovf_sticky: overflow=%b, required 10", overflow);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tests++;
    if (overflow !== 2'b00) begin
      fails++;
      $display("FAIL ovf_clear: overflow=%b, required 00", overflow);
    end
  endtask

  task automatic test_tx_broadcast;
    tx_wr = 1'b1; tx_broadcast = 1'b1; tx_data = 8'h3C;
    tick();
    tx_wr = 1'b1; tx_broadcast = 1'b1; tx_data = 8'hEE;
    tests++;
    if (port_tx_wr !== 2'b11 || port_tx_data !== 8'h3C || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
      fails++;
      $display("FAIL bc_start: wr=%b data=%h busy=%b done=%b, required 11/3C/1/0", port_tx_wr, port_tx_data, tx_busy, tx_done);
    end
    tick();
    idle_inputs();
    for (int c = 2; c < 10; c++) begin
      tests++;
      if (tx_done !== (c == 7) || tx_busy !== (c < 7) || port_tx_wr !== 2'b00 || port_tx_data !== 8'h3C) begin
        fails++;
        $display("FAIL bc_cycle%0d: done=%b busy=%b wr=%b data=%h, required %0b/%0b/00/3C",
                 c, tx_done, tx_busy, port_tx_wr, port_tx_data, (c == 7), (c < 7));
      end
      port_tx_done = (c == 3) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_tx_reply;
    tests++;
    if (lock_port !== 1'b1) begin
      fails++;
      $display("FAIL reply_owner: lock_port=%0d, required 1", lock_port);
    end
    tx_wr = 1'b1; tx_broadcast = 1'b0; tx_data = 8'h5A;
    tick();
    idle_inputs();
    tests++;
    if (port_tx_wr !== 2'b10 || port_tx_data !== 8'h5A) begin
      fails++;
      $display("FAIL reply_wr: wr=%b data=%h, required 10/5A", port_tx_wr, port_tx_data);
    end
    port_tx_done = 2'b01;
    tick();
    port_tx_done = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b1) begin
        fails++;
        $display("FAIL reply_ignore: done=%b busy=%b, required 0/1", tx_done, tx_busy);
      end
      tick();
    end
    port_tx_done = 2'b10;
    tick();
    port_tx_done = 2'b00;
    tests++;
    if (tx_done !== 1'b1) begin
      fails++;
      $display("FAIL reply_done: tx_done=%b, required 1", tx_done);
    end
    tick();
    tests++;
    if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL reply_end: done=%b busy=%b, required 0/0", tx_done, tx_busy);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        tests++;
        if (rx_done !== 1'b0 || locked !== 1'b0 || lock_port !== '0 || overflow !== '0 || rx_data !== 8'h00 ||
            tx_busy !== 1'b0 || tx_done !== 1'b0 || port_tx_wr !== '0 || port_tx_data !== 8'h00 || rx_port !== '0) begin
          fails++;
          $display("FAIL rand_reset: rx_done=%b locked=%b ovf=%b busy=%b wr=%b, required all zero",
                   rx_done, locked, overflow, tx_busy, port_tx_wr);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (rx_done !== 1'b0 || tx_done !== 1'b0 || port_tx_wr !== '0 || locked !== 1'b0) begin
          fails++;
          $display("FAIL rand_post_reset: rx_done=%b tx_done=%b wr=%b locked=%b, required 0/0/00/0",
                   rx_done, tx_done, port_tx_wr, locked);
        end
      end
      port_rx_data   = 16'($urandom);
      for (int i = 0; i < NP; i++) begin
        port_rx_done[i] = ($urandom_range(0, 3) == 0);
        port_tx_done[i] = ($urandom_range(0, 3) == 0);
      end
      packet_end     = ($urandom_range(0, 15) == 0);
      tx_wr          = ($urandom_range(0, 7) == 0);
      tx_broadcast   = 1'($urandom_range(0, 1));
      tx_data        = 8'($urandom);
      clear_overflow = ($urandom_range(0, 31) == 0);
      tick();
      tests++;
      if (rx_done !== m_rx_done || (m_rx_done && (rx_data !== m_rx_data || rx_port !== PW'(m_rx_port)))) begin
        fails++;
        $display("FAIL rand_rx c=%0d: done=%b data=%h port=%0d, required %b/%h/%0d",
                 c, rx_done, rx_data, rx_port, m_rx_done, m_rx_data, m_rx_port);
      end
      tests++;
      if (locked !== m_locked || lock_port !== PW'(m_owner)) begin
        fails++;
        $display("FAIL rand_lock c=%0d: locked=%b lock_port=%0d, required %b/%0d", c, locked, lock_port, m_locked, m_owner);
      end
      tests++;
      if (tx_busy !== m_busy || tx_done !== m_tx_done || port_tx_wr !== m_ptx_wr || port_tx_data !== m_ptx_data) begin
        fails++;
        $display("FAIL rand_tx c=%0d: busy=%b done=%b wr=%b data=%h, required %b/%b/%b/%h",
                 c, tx_busy, tx_done, port_tx_wr, port_tx_data, m_busy, m_tx_done, m_ptx_wr, m_ptx_data);
      end
      tests++;
      if (overflow !== m_ovf) begin
        fails++;
        $display("FAIL rand_ovf c=%0d: overflow=%b, required %b", c, overflow, m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_byte();
    test_lock_hold();
    test_timeout();
    test_overflow();
    test_tx_broadcast();
    test_tx_reply();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
